// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares a dual-port data memory between two pipeline lanes (a = older,
//   b = younger) and a background loader.
//
//   Lanes normally own one port each. Suppose both lanes hit the same address
//   and at least one of them writes. The access is then split over two cycles.
//   Lane a goes first and its read data is parked in hold_a. Lane b follows on
//   the next cycle. As a result, a write from b always lands last, and a read
//   from a always sees the pre-write value.
//
//   The loader takes any idle port, with port b preferred. If it is blocked
//   for STARVE_LIMIT consecutive cycles, it receives a forced cycle on port a.
//   During that forced cycle both lanes are stalled.
//
//   Ports
//     clock, reset              rising-edge clock, async active-low reset
//     a_*/b_*                   lane requests (req, we, addr[11:0], wdata[31:0])
//     ld_valid/ld_we/ld_addr/ld_wdata, ld_ready   loader request / accept
//     a_rdata, b_rdata, ld_rdata                  read data to requesters
//     stall                     pipeline must hold both lanes this cycle
//     address_dmem_*, data_*, wren_*, q_dmem_*    dual-port dmem drive / return
//                               (dmem is clocked on the inverted clock, so q is
//                               valid in the same cycle as the address)
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [11:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [11:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic        ld_valid,
  input  logic        ld_we,
  input  logic [11:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ready,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic [31:0] ld_rdata,
  output logic        stall,
  output logic [11:0] address_dmem_a,
  output logic [11:0] address_dmem_b,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  output logic        wren_a,
  output logic        wren_b,
  input  logic [31:0] q_dmem_a,
  input  logic [31:0] q_dmem_b
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {NORMAL, SPLIT, FORCE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hold_a_q, hold_a_d;

  logic conflict;
  logic wren_a_c, wren_b_c, stall_c, ld_ready_c;

  assign conflict = a_req & b_req & (a_addr == b_addr) & (a_we | b_we);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hold_a_d       = hold_a_q;
    address_dmem_a = '0;
    address_dmem_b = '0;
    data_a         = '0;
    data_b         = '0;
    wren_a_c       = 1'b0;
    wren_b_c       = 1'b0;
    stall_c        = 1'b0;
    ld_ready_c     = 1'b0;
    a_rdata        = q_dmem_a;
    b_rdata        = q_dmem_b;
    ld_rdata       = q_dmem_a;

    case (state_q)
      NORMAL: begin
        if (conflict) begin
          // First half of a split: lane a only. Its read data is parked so
          // that it can be returned again while lane b completes.
          address_dmem_a = a_addr;
          data_a         = a_wdata;
          wren_a_c       = a_we;
          stall_c        = 1'b1;
          hold_a_d       = q_dmem_a;
          state_d        = SPLIT;
          if (ld_valid && cnt_q != LIMIT) cnt_d = cnt_q + CW'(1);
        end else begin
          if (a_req) begin
            address_dmem_a = a_addr;
            data_a         = a_wdata;
            wren_a_c       = a_we;
          end
          if (b_req) begin
            address_dmem_b = b_addr;
            data_b         = b_wdata;
            wren_b_c       = b_we;
          end
          // Loader fills an idle port; port b first, so port a stays free
          // for the older lane.
          if (ld_valid && !b_req) begin
            address_dmem_b = ld_addr;
            data_b         = ld_wdata;
            wren_b_c       = ld_we;
            ld_ready_c     = 1'b1;
            ld_rdata       = q_dmem_b;
          end else if (ld_valid && !a_req) begin
            address_dmem_a = ld_addr;
            data_a         = ld_wdata;
            wren_a_c       = ld_we;
            ld_ready_c     = 1'b1;
            ld_rdata       = q_dmem_a;
          end
          if (ld_ready_c) begin
            cnt_d = '0;
          end else if (ld_valid && cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
          end
          // Moves to FORCE on the same edge that brings the counter to the
          // limit. The forced slot therefore directly follows the
          // STARVE_LIMIT-th blocked cycle.
          if (cnt_d == LIMIT) state_d = FORCE;
        end
      end

      SPLIT: begin
        // Lane inputs are still held by the pipeline. Only b is issued here;
        // lane a already completed in the previous cycle.
        if (b_req) begin
          address_dmem_b = b_addr;
          data_b         = b_wdata;
          wren_b_c       = b_we;
        end
        a_rdata = hold_a_q;
        // A starvation limit reached during the conflict cycle is served next.
        state_d = (cnt_q == LIMIT) ? FORCE : NORMAL;
      end

      FORCE: begin
        stall_c = 1'b1;
        if (ld_valid) begin
          address_dmem_a = ld_addr;
          data_a         = ld_wdata;
          wren_a_c       = ld_we;
          ld_ready_c     = 1'b1;
        end
        ld_rdata = q_dmem_a;
        cnt_d    = '0;
        state_d  = NORMAL;
      end

      default: state_d = NORMAL;
    endcase
  end

  // Control outputs are gated by reset, so an asserted reset silences the
  // memory and the pipeline without waiting for a clock edge.
  assign wren_a   = wren_a_c & reset;
  assign wren_b   = wren_b_c & reset;
  assign stall    = stall_c & reset;
  assign ld_ready = ld_ready_c & reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= NORMAL;
      cnt_q    <= '0;
      hold_a_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_a_q <= hold_a_d;
    end
  end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, default 8, consecutive loader-blocked cycles before a forced grant.
REQ-002 SHALL have port: clock  in  1  master clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: a_req, a_we  in  1 each  lane-a (older lane) memory request and write flag.
REQ-005 SHALL have ports: a_addr  in  12, a_wdata  in  32  lane-a address and write data.
REQ-006 SHALL have ports: b_req, b_we  in  1 each, b_addr  in  12, b_wdata  in  32  lane-b (younger lane) request.
REQ-007 SHALL have ports: ld_valid, ld_we  in  1 each, ld_addr  in  12, ld_wdata  in  32  loader request.
REQ-008 SHALL have port: ld_ready  out  1  loader request accepted this cycle.
REQ-009 SHALL have ports: a_rdata, b_rdata, ld_rdata  out  32 each  read data to each requester.
REQ-010 SHALL have port: stall  out  1  pipeline must hold both lanes this cycle.
REQ-011 SHALL have ports: address_dmem_a, address_dmem_b  out  12, data_a, data_b  out  32, wren_a, wren_b  out  1  dual-port dmem drive.
REQ-012 SHALL have ports: q_dmem_a, q_dmem_b  in  32  dmem read data; valid in the same clock cycle as the address, since dmem is clocked on the inverted clock.

Function
REQ-013 SHALL implement FSM states NORMAL, SPLIT and FORCE.
REQ-014 Conflict SHALL be defined as a_req & b_req & (a_addr==b_addr) & (a_we|b_we).
REQ-015 NORMAL, no conflict: lane a SHALL drive port a, lane b SHALL drive port b, stall=0, a_rdata=q_dmem_a, b_rdata=q_dmem_b.
REQ-016 NORMAL, conflict: only lane a SHALL be issued on port a, wren_b=0, stall=1, q_dmem_a SHALL be captured into hold_a, and the FSM SHALL go to SPLIT.
REQ-017 SPLIT: lane b SHALL be issued on port b, port a SHALL be idle with wren_a=0, a_rdata=hold_a, stall=0, and the FSM SHALL return to NORMAL.
REQ-018 A port SHALL be idle when its lane has no request; an idle port SHALL have wren=0.
REQ-019 Loader in NORMAL: ld_ready SHALL be asserted when a port is idle and no conflict exists; port b SHALL be preferred when both ports are idle; loader signals SHALL drive the granted port.
REQ-020 ld_rdata SHALL equal q of the granted port in the ld_ready cycle; it is don't-care for writes or when ld_ready=0.
REQ-021 Starvation counter: SHALL increment each NORMAL cycle with ld_valid=1 and ld_ready=0, clear on any ld_ready, hold when ld_valid=0, and saturate at STARVE_LIMIT.
REQ-022 NORMAL with counter==STARVE_LIMIT and no conflict SHALL enter FORCE on the next edge; a conflict SHALL take priority, and FORCE is entered after SPLIT completes.
REQ-023 FORCE: stall=1, both lanes SHALL be blocked with wren_a=wren_b=0 for lane traffic, the loader SHALL own port a with ld_ready=ld_valid, the counter SHALL clear, and the FSM SHALL go to NORMAL.
REQ-024 FORCE with ld_valid=0 on entry SHALL return to NORMAL with no memory access and stall=1 for that cycle.
REQ-025 In SPLIT and FORCE the stalled lane inputs SHALL be held by the pipeline; the arbiter SHALL NOT re-issue lane a in SPLIT.
REQ-026 Two writes to the same address SHALL resolve with lane b data as the final memory value; a lane-a read paired with a lane-b write SHALL return pre-write data.
REQ-027 Lane request outputs SHALL be combinational from state and inputs; state, counter and hold_a SHALL be the only registers.

Reset
REQ-028 Reset low SHALL immediately force: state=NORMAL, counter=0, hold_a=0, stall=0, ld_ready=0, wren_a=wren_b=0.
REQ-029 Reset asserted in SPLIT or FORCE SHALL abandon the pending access; after release the FSM SHALL be in NORMAL with no access issued.

Verification
REQ-030 Parallel: a read 0x010, b write 0x020 data 0xDEADBEEF -> same cycle, stall=0, wren_b=1, address_dmem_b=0x020.
REQ-031 Conflict: a write 0x040 data 1, b write 0x040 data 2 -> cycle 1 wren_a=1 and stall=1; cycle 2 wren_b=1 and stall=0; mem[0x040]=2.
REQ-032 Conflict read: a read 0x040 (mem=5), b write 0x040 data 9 -> a_rdata=5 in both cycles; mem[0x040]=9.
REQ-033 Starvation: both lanes busy, ld_valid=1 for 8 cycles -> cycle 9 stall=1, ld_ready=1 on port a, counter=0.
REQ-034 Loader idle slot: a_req=1, b_req=0, ld_valid=1 -> ld_ready=1 on port b the same cycle.
REQ-035 Reset mid-SPLIT -> on release, state NORMAL, wren_b=0, stall=0.
